// File: rtl/prog_sequencer_if.sv
// Handshake/bus bundle between the program sequencer and its environment (bench, decoder, LUT).
// Optional macro PROG_SEQ_CYCLE_CNT_EN adds the cycle_cnt readout.
interface prog_sequencer_if #(
    parameter int unsigned PC_W = 10
);
    localparam int unsigned PROG_W = 2;
    localparam int unsigned CNT_W  = 16;

    logic              start;
    logic              halt;
    logic              branch_taken;
    logic [PC_W-1:0]   PC_target;
    logic [PC_W-1:0]   PC;
    logic [PROG_W-1:0] prog_state;
    logic              run;
    logic              done;
`ifdef PROG_SEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0]  cycle_cnt;
`endif

    // Sequencer side
    modport master (
        input  start, halt, branch_taken, PC_target,
`ifdef PROG_SEQ_CYCLE_CNT_EN
        output cycle_cnt,
`endif
        output PC, prog_state, run, done
    );

    // Environment side
    modport slave (
        output start, halt, branch_taken, PC_target,
`ifdef PROG_SEQ_CYCLE_CNT_EN
        input  cycle_cnt,
`endif
        input  PC, prog_state, run, done
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program-level controller and PC generator for the three-program demo CPU.
// Optional macro PROG_SEQ_CYCLE_CNT_EN adds a saturating RUN-cycle counter.
module prog_sequencer #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned START_P0  = 0,
    parameter int unsigned START_P1  = 256,
    parameter int unsigned START_P2  = 512,
    parameter int unsigned NUM_PROGS = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    prog_sequencer_if.master bus
);
    localparam int unsigned PROG_W = 2;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PROG_W-1:0] prog_state_q, prog_state_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
`ifdef PROG_SEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            prog_state_q <= '0;
            run_q        <= 1'b0;
            done_q       <= 1'b0;
`ifdef PROG_SEQ_CYCLE_CNT_EN
            cycle_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prog_state_q <= prog_state_d;
            run_q        <= run_d;
            done_q       <= done_d;
`ifdef PROG_SEQ_CYCLE_CNT_EN
            cycle_cnt_q  <= cycle_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        prog_state_d = prog_state_q;

        // An illegal program index can only come from corruption; recover to a clean start.
        if (prog_state_q == PROG_W'(3)) begin
            state_d      = IDLE;
            prog_state_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) state_d = INIT;
                end
                INIT: begin
                    case (prog_state_q)
                        PROG_W'(0): pc_d = PC_W'(START_P0);
                        PROG_W'(1): pc_d = PC_W'(START_P1);
                        default:    pc_d = PC_W'(START_P2);
                    endcase
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.halt) begin
                        state_d = DONE;
                    end else if (bus.branch_taken) begin
                        pc_d = bus.PC_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        prog_state_d = (prog_state_q == PROG_W'(NUM_PROGS - 1))
                                     ? '0 : prog_state_q + PROG_W'(1);
                        state_d      = INIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        run_d  = (state_d == RUN);
        done_d = (state_d == DONE);
    end

`ifdef PROG_SEQ_CYCLE_CNT_EN
    // Zero while in INIT; counts every RUN cycle including the halting one.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == INIT) begin
            cycle_cnt_d = '0;
        end else if (state_q == RUN && cycle_cnt_q != {CNT_W{1'b1}}) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
`endif

    assign bus.PC         = pc_q;
    assign bus.prog_state = prog_state_q;
    assign bus.run        = run_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer; define PROG_SEQ_CYCLE_CNT_EN to also check cycle_cnt.
module tb_prog_sequencer;
    localparam int unsigned PC_W = 10;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    prog_sequencer_if #(.PC_W(PC_W)) bus ();

    prog_sequencer #(.PC_W(PC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int pc, input int ps, input int run, input int done);
        check_eq({tag, ".pc"},   32'(bus.PC),         32'(pc));
        check_eq({tag, ".ps"},   32'(bus.prog_state), 32'(ps));
        check_eq({tag, ".run"},  32'(bus.run),        32'(run));
        check_eq({tag, ".done"}, 32'(bus.done),       32'(done));
    endtask

    // Start from DONE: one edge into INIT, a second edge into RUN at the program start.
    task automatic start_prog(input string tag, input int ps, input int start_pc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq({tag, ".init_ps"},  32'(bus.prog_state), 32'(ps));
        check_eq({tag, ".init_run"}, 32'(bus.run),        32'd0);
        tick();
        check_outs({tag, ".run"}, start_pc, ps, 1, 0);
    endtask

    task automatic halt_prog();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
    endtask

    initial begin
        n_cmp            = 0;
        n_bad            = 0;
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.halt         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.PC_target    = '0;

        tick();
        tick();
        check_outs("reset", 0, 0, 0, 0);

        // First start from IDLE
        reset_n = 1'b1;
        tick();
        check_outs("idle_hold", 0, 0, 0, 0);
        start_prog("p0", 0, 0);
        tick(); check_eq("cnt1", 32'(bus.PC), 32'd1);
        tick(); check_eq("cnt2", 32'(bus.PC), 32'd2);
        tick(); check_eq("cnt3", 32'(bus.PC), 32'd3);

        // start during RUN is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_outs("start_in_run", 4, 0, 1, 0);
        tick(); check_eq("pc5", 32'(bus.PC), 32'd5);

        // Branch redirect
        bus.branch_taken = 1'b1;
        bus.PC_target    = 10'd40;
        tick();
        bus.branch_taken = 1'b0;
        check_outs("branch", 40, 0, 1, 0);
        tick(); check_eq("post_branch", 32'(bus.PC), 32'd41);

        bus.branch_taken = 1'b1;
        bus.PC_target    = 10'd6;
        tick();
        bus.branch_taken = 1'b0;
        check_eq("branch6", 32'(bus.PC), 32'd6);
        tick(); check_eq("pc7", 32'(bus.PC), 32'd7);

        // halt beats branch
        bus.halt         = 1'b1;
        bus.branch_taken = 1'b1;
        bus.PC_target    = 10'd99;
        tick();
        bus.halt         = 1'b0;
        bus.branch_taken = 1'b0;
        check_outs("halt_prio", 7, 0, 0, 1);
        tick();
        check_outs("done_hold", 7, 0, 0, 1);

        // Program rotation
        start_prog("p1", 1, 256);
        tick(); check_eq("p1_inc", 32'(bus.PC), 32'd257);
        halt_prog();
        check_outs("p1_done", 257, 1, 0, 1);
        start_prog("p2", 2, 512);
        halt_prog();
        check_outs("p2_done", 512, 2, 0, 1);
        start_prog("p0b", 0, 0);

        // PC wrap
        bus.branch_taken = 1'b1;
        bus.PC_target    = 10'd1023;
        tick();
        bus.branch_taken = 1'b0;
        check_eq("pc1023", 32'(bus.PC), 32'd1023);
        tick();
        check_outs("wrap", 0, 0, 1, 0);
        tick();
        check_eq("after_wrap", 32'(bus.PC), 32'd1);

        // Mid-run reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_outs("mid_reset", 0, 0, 0, 0);
        tick();
        check_outs("post_reset_idle", 0, 0, 0, 0);

`ifdef PROG_SEQ_CYCLE_CNT_EN
        check_eq("cc_reset", 32'(bus.cycle_cnt), 32'd0);
        start_prog("cc", 0, 0);
        for (int i = 0; i < 11; i++) tick();
        check_eq("cc_11", 32'(bus.cycle_cnt), 32'd11);
        halt_prog();
        check_eq("cc_done", 32'(bus.cycle_cnt), 32'd12);
        check_outs("cc_done_st", 11, 0, 0, 1);
        tick();
        check_eq("cc_hold", 32'(bus.cycle_cnt), 32'd12);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("cc_init_clr", 32'(bus.cycle_cnt), 32'd0);
        check_eq("cc_init_ps", 32'(bus.prog_state), 32'd1);
        tick();
        check_eq("cc_run0", 32'(bus.cycle_cnt), 32'd0);
        tick();
        check_eq("cc_run1", 32'(bus.cycle_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
